// File: rtl/match_controller.sv
// rtl/match_controller.sv - round sequencer and scoreboard wrapped around full_game
//
// Starts each round of full_game with a one-cycle init pulse carrying the
// sampled seed and counter mode, detects the end of the round from a rising
// edge on gameover, credits the round to the player named by who, and
// declares a match winner once a player reaches ROUNDS_TO_WIN rounds.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   request a new match (honoured in IDLE and DONE only)
//   seed_val     in   initial counter value for each round
//   mode         in   counter mode for each round
//   gameover     in   from full_game, high once the round has ended
//   who          in   from full_game, 1 = player A took the round, 0 = player B
//   init         out  one-cycle load pulse to full_game
//   initial_val  out  seed forwarded to full_game, held through the round
//   control      out  mode forwarded to full_game, held through the round
//   score_a      out  rounds won by player A
//   score_b      out  rounds won by player B
//   round_cnt    out  rounds completed, saturating at 15
//   busy         out  high while a match is in progress (LOAD, PLAY, GAP)
//   match_over   out  high once a match has been decided
//   match_winner out  1 = A, 0 = B; valid while match_over is high

module match_controller #(
  parameter int ROUNDS_TO_WIN = 3,
  parameter int RESTART_GAP   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] seed_val,
  input  logic [1:0] mode,
  input  logic       gameover,
  input  logic       who,
  output logic       init,
  output logic [3:0] initial_val,
  output logic [1:0] control,
  output logic [2:0] score_a,
  output logic [2:0] score_b,
  output logic [3:0] round_cnt,
  output logic       busy,
  output logic       match_over,
  output logic       match_winner
);

  localparam logic [2:0] WIN_SCORE = 3'(ROUNDS_TO_WIN);
  localparam logic [3:0] GAP_LAST  = 4'(RESTART_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_next;

  // Last-seen gameover level; a round only ends on a 0 -> 1 transition.
  logic       go_hist;
  logic [3:0] gap_cnt;

  logic       round_end;
  logic       gap_done;
  logic       win;
  logic [2:0] score_a_inc;
  logic [2:0] score_b_inc;

  assign round_end   = (state == S_PLAY) && gameover && !go_hist;
  assign gap_done    = (gap_cnt == GAP_LAST);
  assign score_a_inc = score_a + 3'd1;
  assign score_b_inc = score_b + 3'd1;
  assign win         = who ? (score_a_inc == WIN_SCORE) : (score_b_inc == WIN_SCORE);

  // Status outputs are pure decodes of the registered state.
  assign init        = (state == S_LOAD);
  assign busy        = (state == S_LOAD) || (state == S_PLAY) || (state == S_GAP);
  assign match_over  = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  state_next = S_PLAY;
      S_PLAY:  if (round_end) state_next = win ? S_DONE : S_GAP;
      S_GAP:   if (gap_done) state_next = S_LOAD;
      S_DONE:  if (start) state_next = S_LOAD;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      initial_val  <= 4'd0;
      control      <= 2'd0;
      score_a      <= 3'd0;
      score_b      <= 3'd0;
      round_cnt    <= 4'd0;
      match_winner <= 1'b0;
      go_hist      <= 1'b1;
      gap_cnt      <= 4'd0;
    end else begin
      // Forcing the history high while loading means a gameover left high
      // by the previous round must be seen low in PLAY before it can count.
      go_hist <= (state == S_LOAD) ? 1'b1 : gameover;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            score_a     <= 3'd0;
            score_b     <= 3'd0;
            round_cnt   <= 4'd0;
            initial_val <= seed_val;
            control     <= mode;
          end
        end
        S_PLAY: begin
          if (round_end) begin
            if (who) begin
              score_a <= score_a_inc;
            end else begin
              score_b <= score_b_inc;
            end
            if (round_cnt != 4'd15) begin
              round_cnt <= round_cnt + 4'd1;
            end
            if (win) begin
              match_winner <= who;
            end
            gap_cnt <= 4'd0;
          end
        end
        S_GAP: begin
          if (gap_done) begin
            initial_val <= seed_val;
            control     <= mode;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
